// File: rtl/oisc8_pkg.sv
// Shared OISC8 core constants: bus field widths, special port addresses and
// the fetch-stage state encoding.
package oisc8_pkg;

  localparam int SAWIDTH     = 8;
  localparam int DAWIDTH     = 4;
  localparam int INSTR_WIDTH = SAWIDTH + DAWIDTH + 1;

  localparam logic [DAWIDTH-1:0] DST_NOP  = 4'hF;
  localparam logic [DAWIDTH-1:0] DST_BRZ  = 4'd4;
  localparam logic [SAWIDTH-1:0] SRC_NULL = '0;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } e_fetch_state;

endpackage

// File: rtl/oisc8_fetch_if.sv
// Fetch-stage bundle: program memory port plus the instruction side of the
// shared data bus. The master side is the fetch stage.
interface oisc8_fetch_if #(
  parameter int AW = 16
);

  logic [AW-1:0]                      pm_addr;
  logic                               pm_rd;
  logic [oisc8_pkg::INSTR_WIDTH-1:0]  pm_data;
  logic                               stall;
  logic [7:0]                         bus_data;
  logic [AW-1:0]                      br_target;
  logic [3:0]                         instr_dst;
  logic [7:0]                         instr_src;
  logic                               imm;
  logic [7:0]                         imm_data;
  logic [AW-1:0]                      pc;
  logic                               valid;

  modport master (
    output pm_addr, pm_rd, instr_dst, instr_src, imm, imm_data, pc, valid,
    input  pm_data, stall, bus_data, br_target
  );

  modport slave (
    input  pm_addr, pm_rd, instr_dst, instr_src, imm, imm_data, pc, valid,
    output pm_data, stall, bus_data, br_target
  );

endinterface

// File: rtl/oisc8_instr_decode.sv
// Combinational instruction decode; emits a NOP whenever issue is disabled.
module oisc8_instr_decode
  import oisc8_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0] pm_data,
  input  logic                   issue_en,
  output logic [DAWIDTH-1:0]     instr_dst,
  output logic [SAWIDTH-1:0]     instr_src,
  output logic                   imm,
  output logic [7:0]             imm_data,
  output logic                   valid
);

  always_comb begin
    instr_dst = DST_NOP;
    instr_src = SRC_NULL;
    imm       = 1'b0;
    imm_data  = 8'h00;
    valid     = 1'b0;
    if (issue_en) begin
      valid     = 1'b1;
      instr_dst = pm_data[SAWIDTH +: DAWIDTH];
      imm       = pm_data[INSTR_WIDTH-1];
      // an immediate owns the bus, so no port may source it
      if (pm_data[INSTR_WIDTH-1]) begin
        imm_data = pm_data[SAWIDTH-1:0];
      end else begin
        instr_src = pm_data[SAWIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/oisc8_fetch.sv
// OISC8 fetch/issue stage: PC sequencing, stall hold and BRZ resolution with
// a single FLUSH bubble for taken branches.
module oisc8_fetch
  import oisc8_pkg::*;
#(
  parameter int                     PROG_AWIDTH = 16,
  parameter logic [PROG_AWIDTH-1:0] RESET_PC    = '0
) (
  input  logic          clk,
  input  logic          rst,
  oisc8_fetch_if.master fb
);

  localparam logic [1:0] S_FILL  = FILL;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_FLUSH = FLUSH;

  logic [1:0]             state_q, state_d;
  logic [PROG_AWIDTH-1:0] fa_q, fa_d;
  logic [PROG_AWIDTH-1:0] ep_q, ep_d;
  logic                   issue;
  logic                   hold;
  logic                   br_taken;
  logic [DAWIDTH-1:0]     dec_dst;

  assign issue    = (state_q == S_RUN);
  assign hold     = issue && fb.stall;
  assign br_taken = issue && !fb.stall && (dec_dst == DST_BRZ) && (fb.bus_data == 8'h00);

  oisc8_instr_decode u_dec (
    .pm_data   (fb.pm_data),
    .issue_en  (issue),
    .instr_dst (dec_dst),
    .instr_src (fb.instr_src),
    .imm       (fb.imm),
    .imm_data  (fb.imm_data),
    .valid     (fb.valid)
  );

  always_comb begin
    state_d = state_q;
    fa_d    = fa_q;
    ep_d    = ep_q;
    case (state_q)
      S_FILL, S_FLUSH: begin
        state_d = S_RUN;
        ep_d    = fa_q;
        fa_d    = fa_q + PROG_AWIDTH'(1);
      end
      S_RUN: begin
        if (!fb.stall) begin
          // the word being read at fa is the wrong path; FLUSH drops it
          if (br_taken) begin
            state_d = S_FLUSH;
            fa_d    = fb.br_target;
          end else begin
            ep_d = fa_q;
            fa_d = fa_q + PROG_AWIDTH'(1);
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      fa_q    <= RESET_PC;
      ep_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      ep_q    <= ep_d;
    end
  end

  // fa already holds br_target during FLUSH, so pm_addr is always fa
  assign fb.pm_addr   = fa_q;
  assign fb.pm_rd     = !rst && !hold;
  assign fb.instr_dst = dec_dst;
  assign fb.pc        = ep_q;

endmodule

// File: tb/tb_oisc8_fetch.sv
// Bench for oisc8_fetch: directed cycle checks plus an in-order scoreboard of
// issued instructions; a second instance starts at 16'hFFFF for wrap-around.
module tb_oisc8_fetch;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  dst;
    logic [7:0]  src;
    logic        imm;
    logic [7:0]  immd;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [7:0]  bus_drv;
  logic [12:0] rom [0:65535];
  exp_t        sb [$];
  int          n_chk = 0;
  int          n_err = 0;

  oisc8_fetch_if #(.AW(16)) f1 ();
  oisc8_fetch_if #(.AW(16)) f2 ();

  oisc8_fetch #(.PROG_AWIDTH(16), .RESET_PC(16'h0000)) u_dut (
    .clk (clk),
    .rst (rst),
    .fb  (f1)
  );

  oisc8_fetch #(.PROG_AWIDTH(16), .RESET_PC(16'hFFFF)) u_wrap (
    .clk (clk),
    .rst (rst),
    .fb  (f2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign f1.stall     = stall;
  assign f1.br_target = 16'h0040;
  assign f1.bus_data  = f1.imm ? f1.imm_data : bus_drv;
  assign f2.stall     = 1'b0;
  assign f2.br_target = 16'h0040;
  assign f2.bus_data  = f2.imm ? f2.imm_data : 8'hFF;

  always @(posedge clk) if (f1.pm_rd) f1.pm_data <= rom[f1.pm_addr];
  always @(posedge clk) if (f2.pm_rd) f2.pm_data <= rom[f2.pm_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] pc, input logic [12:0] w);
    exp_t e;
    e.pc   = pc;
    e.dst  = w[11:8];
    e.imm  = w[12];
    e.src  = w[12] ? 8'h00 : w[7:0];
    e.immd = w[12] ? w[7:0] : 8'h00;
    sb.push_back(e);
  endtask

  // every completing instruction must match the next expected issue
  always begin
    @(negedge clk);
    #3;
    if (!rst && f1.valid && !f1.stall) begin
      if (sb.size() == 0) begin
        chk("sb_extra_pc", {16'h0, f1.pc}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc",   {16'h0, f1.pc},     {16'h0, e.pc});
        chk("sb_dst",  {28'h0, f1.instr_dst}, {28'h0, e.dst});
        chk("sb_src",  {24'h0, f1.instr_src}, {24'h0, e.src});
        chk("sb_imm",  {31'h0, f1.imm},    {31'h0, e.imm});
        chk("sb_immd", {24'h0, f1.imm_data}, {24'h0, e.immd});
      end
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 13'h0;
    rom[16'h0000] = {1'b0, 4'd13, 8'd36};
    rom[16'h0001] = {1'b1, 4'd0,  8'h5A};
    rom[16'h0002] = {1'b1, 4'd4,  8'h00};
    rom[16'h0003] = {1'b0, 4'd7,  8'd99};
    rom[16'h0040] = {1'b0, 4'd2,  8'd10};
    rom[16'h0041] = {1'b1, 4'd4,  8'h01};
    rom[16'h0042] = {1'b0, 4'd3,  8'd20};
    rom[16'h0043] = {1'b0, 4'd4,  8'd5};
    rst = 1'b1; stall = 1'b0; bus_drv = 8'h00;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_addr",  {16'h0, f1.pm_addr}, 32'h0);
    chk("rst_pc",    {16'h0, f1.pc}, 32'h0);
    chk("rst_rd",    {31'h0, f1.pm_rd}, 32'h0);
    chk("rst_valid", {31'h0, f1.valid}, 32'h0);
    chk("rst_dst",   {28'h0, f1.instr_dst}, 32'hF);
    chk("rst_src",   {24'h0, f1.instr_src}, 32'h0);
    chk("rst_wrap_addr", {16'h0, f2.pm_addr}, 32'hFFFF);

    push(16'h0000, rom[16'h0000]);
    push(16'h0001, rom[16'h0001]);
    push(16'h0002, rom[16'h0002]);
    push(16'h0040, rom[16'h0040]);
    push(16'h0041, rom[16'h0041]);
    push(16'h0042, rom[16'h0042]);
    push(16'h0043, rom[16'h0043]);

    @(negedge clk); rst = 1'b0; #1;
    chk("fill_valid", {31'h0, f1.valid}, 32'h0);
    chk("fill_dst",   {28'h0, f1.instr_dst}, 32'hF);
    chk("fill_addr",  {16'h0, f1.pm_addr}, 32'h0);
    chk("fill_rd",    {31'h0, f1.pm_rd}, 32'h1);

    @(negedge clk); #1;
    chk("c2_pc",   {16'h0, f1.pc}, 32'h0);
    chk("c2_dst",  {28'h0, f1.instr_dst}, 32'd13);
    chk("c2_src",  {24'h0, f1.instr_src}, 32'd36);
    chk("c2_addr", {16'h0, f1.pm_addr}, 32'h1);
    chk("wrap_pc_hi",   {16'h0, f2.pc}, 32'hFFFF);
    chk("wrap_addr_lo", {16'h0, f2.pm_addr}, 32'h0);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk); stall = (k < 3); #1;
      chk("stl_pc",   {16'h0, f1.pc}, 32'h1);
      chk("stl_imm",  {31'h0, f1.imm}, 32'h1);
      chk("stl_immd", {24'h0, f1.imm_data}, 32'h5A);
      chk("stl_src",  {24'h0, f1.instr_src}, 32'h0);
      chk("stl_addr", {16'h0, f1.pm_addr}, 32'h2);
      chk("stl_rd",   {31'h0, f1.pm_rd}, (k < 3) ? 32'h0 : 32'h1);
      if (k == 0) chk("wrap_pc_lo", {16'h0, f2.pc}, 32'h0);
    end
    stall = 1'b0;

    @(negedge clk); #1;
    chk("brz_pc",   {16'h0, f1.pc}, 32'h2);
    chk("brz_dst",  {28'h0, f1.instr_dst}, 32'h4);
    chk("brz_addr", {16'h0, f1.pm_addr}, 32'h3);

    @(negedge clk); stall = 1'b1; #1;
    chk("fl_valid", {31'h0, f1.valid}, 32'h0);
    chk("fl_dst",   {28'h0, f1.instr_dst}, 32'hF);
    chk("fl_src",   {24'h0, f1.instr_src}, 32'h0);
    chk("fl_addr",  {16'h0, f1.pm_addr}, 32'h40);
    chk("fl_rd",    {31'h0, f1.pm_rd}, 32'h1);

    @(negedge clk); stall = 1'b0; #1;
    chk("tgt_pc", {16'h0, f1.pc}, 32'h40);
    @(negedge clk); #1;
    chk("nt_pc",   {16'h0, f1.pc}, 32'h41);
    chk("nt_immd", {24'h0, f1.imm_data}, 32'h01);
    @(negedge clk); #1;
    chk("nt_next_pc",    {16'h0, f1.pc}, 32'h42);
    chk("nt_next_valid", {31'h0, f1.valid}, 32'h1);
    @(negedge clk); #1;
    chk("brz2_pc", {16'h0, f1.pc}, 32'h43);

    @(negedge clk); #1;
    chk("fl2_valid", {31'h0, f1.valid}, 32'h0);
    chk("fl2_addr",  {16'h0, f1.pm_addr}, 32'h40);
    #1 rst = 1'b1;
    #1;
    chk("arst_addr",  {16'h0, f1.pm_addr}, 32'h0);
    chk("arst_pc",    {16'h0, f1.pc}, 32'h0);
    chk("arst_rd",    {31'h0, f1.pm_rd}, 32'h0);
    chk("arst_valid", {31'h0, f1.valid}, 32'h0);
    chk("arst_dst",   {28'h0, f1.instr_dst}, 32'hF);

    @(negedge clk);
    rom[16'h0002] = {1'b1, 4'd4, 8'h01};
    rom[16'h0004] = {1'b0, 4'd1, 8'd1};
    for (int a = 0; a < 5; a++) push(16'(a), rom[a]);

    @(negedge clk); rst = 1'b0; #1;
    chk("refill_valid", {31'h0, f1.valid}, 32'h0);
    chk("refill_addr",  {16'h0, f1.pm_addr}, 32'h0);
    chk("refill_rd",    {31'h0, f1.pm_rd}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("seq_pc",    {16'h0, f1.pc}, k);
      chk("seq_valid", {31'h0, f1.valid}, 32'h1);
    end

    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/oisc8_fetch.md
# oisc8_fetch

Instruction fetch and issue stage of the OISC8 core, sitting directly upstream of the bus port registers. It sequences the program counter, reads 13-bit instructions from synchronous program memory, and decodes each into destination, source and immediate fields. These fields drive the instruction side of the shared data bus. It also resolves BRZ branches and squashes the wrong-path instruction.

## Interface
- `PROG_AWIDTH`, default 16: program memory address width.
- `RESET_PC`, default 0: first fetch address after reset.
- `clk  in  1`: core clock, all state on rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `pm_addr  out  PROG_AWIDTH`: program memory address, registered.
- `pm_rd  out  1`: program memory read enable.
  - Memory returns `pm_data` one cycle after an enabled read.
  - Memory holds `pm_data` while `pm_rd`=0.
- `pm_data  in  13`: instruction word, laid out as {imm[12], dst[11:8], src[7:0]}.
- `stall  in  1`: slow port request to hold the instruction currently on the bus.
- `bus_data  in  8`: resolved bus data, observed for BRZ.
- `br_target  in  PROG_AWIDTH`: branch target, {BRPT1, BRPT0} register contents.
- `instr_dst  out  4`: bus destination address.
- `instr_src  out  8`: bus source address.
- `imm  out  1`: current instruction carries an immediate.
- `imm_data  out  8`: immediate value.
  - The top level drives it onto the bus through a tri-state buffer enabled by `imm`.
- `pc  out  PROG_AWIDTH`: address of the instruction currently on the bus; feeds the PC0/PC1 sources.
- `valid  out  1`: a real (non-NOP) instruction is on the bus.

## Operation
- **Registers:**
  - `fa`: fetch address, mirrored on `pm_addr`.
  - `ep`: executing address, mirrored on `pc`.
  - `state`: one of FILL, RUN, FLUSH.
- **NOP:** `instr_dst`=DST_NOP (4'hF, decodes to no port), `instr_src`=NULL (0), `imm`=0, `imm_data`=0, `valid`=0.
- **Output decode:** outputs are combinational from `pm_data`, gated by state.
  - FILL or FLUSH: outputs are NOP.
  - RUN: outputs are decoded from `pm_data`.
- **Immediate instruction (imm=1):**
  - `imm_data`=src field.
  - `instr_src` is forced to NULL, so no port drives the bus.
  - `instr_dst`=dst field.
- **Non-immediate instruction:** `imm_data`=0 and fields pass through unchanged.
- **Completion:** an instruction completes in the first RUN cycle with `stall`=0.
- **FILL:** `pm_rd`=1 and `pm_addr`=`fa`. Next cycle: state RUN, `ep`<=`fa`, `fa`<=`fa`+1.
- **RUN, no stall, no branch:** `pm_rd`=1, `ep`<=`fa`, `fa`<=`fa`+1.
- **RUN, stall=1:**
  - `pm_rd`=0.
  - `fa` and `ep` are held, and all decoded outputs are held stable.
  - A branch is not evaluated.
- **RUN, completing, branch:**
  - Branch condition: `instr_dst`==BRZ (4) and `bus_data`==0.
  - Actions: `fa`<=`br_target`, state to FLUSH.
  - The word at old `fa` is discarded.
- **FLUSH:**
  - Outputs are NOP, `pm_rd`=1, `pm_addr`=`br_target`.
  - `stall` is ignored.
  - Next cycle: state RUN, `ep`<=`fa`, `fa`<=`fa`+1.
- **BRZ with nonzero data:** no branch; behaves as a normal write.
- **Address arithmetic:** `fa` increments modulo 2^PROG_AWIDTH, so all-ones wraps to 0. `br_target` is used unmodified.
- **Immediate to BRZ:**
  - A value of 0 branches.
  - `bus_data` is the driven immediate, since the top level loops `imm_data` onto the bus.

## Timing
- **Reset values:**
  - `pm_addr`=RESET_PC, `pc`=RESET_PC, `pm_rd`=0, state FILL.
  - Decoded outputs take NOP values, `valid`=0.
  - Assertion is asynchronous: outputs go to NOP within the same cycle, including mid-stall or mid-FLUSH.
- **Startup:** after reset deasserts, FILL lasts 1 cycle. The instruction at RESET_PC is on the bus in the 2nd cycle.
- **Throughput:** 1 instruction per cycle in RUN.
- **Taken branch:** 1 bubble cycle (FLUSH). The target instruction is on the bus 2 cycles after the BRZ cycle.
- **Stall latency:** `stall` is sampled in the same cycle; a stalled instruction stays for every cycle `stall`=1, plus 1 completing cycle.
- **`pm_rd` low cycles:** `pm_rd` is low only during reset and stall cycles.

## Structure
- **Add to `oisc8_pkg`:**
  - `INSTR_WIDTH` = `SAWIDTH` + `DAWIDTH` + 1.
  - `DST_NOP` = 4'hF.
  - The `e_fetch_state` enum {FILL, RUN, FLUSH}.
- **Sub-module `oisc8_instr_decode`:**
  - Combinational.
  - Inputs: `pm_data` and an issue enable.
  - Outputs: `instr_dst`, `instr_src`, `imm`, `imm_data`, `valid`.
- **`oisc8_fetch` contains:** the FSM, the `fa`/`ep` registers, and branch detection.

## Test plan
- **Reset then run:** reset, RESET_PC=0, ROM[0]={0,4'd13,8'd36}, ROM[1]={1,4'd0,8'h5A}.
  - Cycle 1 after reset: NOP, `pm_addr`=0.
  - Cycle 2: `instr_dst`=13, `instr_src`=36, `pc`=0.
  - Cycle 3: `imm`=1, `imm_data`=5A, `instr_src`=0.
- **Stall:** assert `stall` for 3 cycles on ROM[1].
  - Outputs are held for 4 cycles.
  - `pm_rd`=0 for 3 cycles.
  - `pc` stays 1.
- **Branch taken:** ROM[2]={1,4'd4,8'h00}, `br_target`=16'h0040.
  - Next cycle: NOP with `valid`=0.
  - Following cycle: `pc`=0x40.
  - The ROM[3] word never issues.
- **Branch not taken:** same, with immediate 8'h01. `pc` proceeds to 3 with no bubble.
- **Wrap-around:** RESET_PC=16'hFFFF. The sequence `pc`=FFFF is followed by `pc`=0000.
- **Async reset mid-FLUSH:** assert `rst` between clock edges during FLUSH.
  - Outputs go to NOP immediately and `pm_addr`=RESET_PC.
  - The FILL sequence restarts after deassertion.
